// File: rtl/ysyx_24110015_stage_seq_pkg.sv
// Shared types and constants for the instruction stage sequencer.
package ysyx_24110015_stage_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } seq_state_e;

  localparam int IFU = 0;
  localparam int IDU = 1;
  localparam int EXU = 2;
  localparam int LSU = 3;
  localparam int WBU = 4;

  localparam int NSTAGE_DEF = 5;
  localparam int CNT_W_DEF  = 32;
  localparam int TMO_W_DEF  = 8;

endpackage

// File: rtl/ysyx_24110015_stage_seq_if.sv
// Bundle of stage handshake, control and status signals around the sequencer.
interface ysyx_24110015_stage_seq_if
  import ysyx_24110015_stage_seq_pkg::*;
#(
  parameter int NSTAGE = NSTAGE_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int TMO_W  = TMO_W_DEF
);

  logic [NSTAGE-1:0] stage_done;
  logic [NSTAGE-1:0] stage_skip;
  logic              flush;
  logic              halt_req;
  logic [TMO_W-1:0]  tmo_limit;
  logic [NSTAGE-1:0] stage_en;
  logic              commit;
  logic              halted;
  logic [CNT_W-1:0]  instret;
  logic              tmo_err;

  modport master (
    output stage_done, stage_skip, flush, halt_req, tmo_limit,
    input  stage_en, commit, halted, instret, tmo_err
  );

  modport slave (
    input  stage_done, stage_skip, flush, halt_req, tmo_limit,
    output stage_en, commit, halted, instret, tmo_err
  );

endinterface

// File: rtl/ysyx_24110015_seq_wdog.sv
// Stall watchdog: counts RUN cycles without progress, fires once the count hits tmo_limit.
module ysyx_24110015_seq_wdog #(
  parameter int TMO_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clear,
  input  logic [TMO_W-1:0] tmo_limit,
  output logic             fire,
  output logic             tmo_err
);

  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // fire is raised in the cycle whose edge brings the count up to the limit
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    fire  = 1'b0;
    if (run) begin
      if (clear) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + TMO_W'(1);
        if ((tmo_limit != '0) && (cnt_d == tmo_limit)) begin
          fire  = 1'b1;
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign tmo_err = err_q;

endmodule

// File: rtl/ysyx_24110015_stage_seq.sv
// One-hot IFU..WBU stage sequencer with commit counting and ebreak halt.
// Optional stall watchdog is built only when YSYX_24110015_SEQ_WDOG_EN is defined.
module ysyx_24110015_stage_seq
  import ysyx_24110015_stage_seq_pkg::*;
#(
  parameter int NSTAGE = NSTAGE_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int TMO_W  = TMO_W_DEF
) (
  input logic                    clk,
  input logic                    rst,
  ysyx_24110015_stage_seq_if.slave bus
);

  seq_state_e        state_q, state_d;
  logic [NSTAGE-1:0] stage_en_q, stage_en_d;
  logic              commit_q, commit_d;
  logic [CNT_W-1:0]  instret_q, instret_d;

  logic hit;
  logic last;
  logic wdog_fire;

  // only the currently enabled stage may move the sequence forward
  assign hit  = |(stage_en_q & (bus.stage_done | bus.stage_skip));
  assign last = stage_en_q[NSTAGE-1];

  always_comb begin
    state_d    = state_q;
    stage_en_d = stage_en_q;
    commit_d   = 1'b0;
    instret_d  = instret_q;
    case (state_q)
      IDLE: begin
        state_d    = RUN;
        stage_en_d = NSTAGE'(1);
      end
      RUN: begin
        if (bus.flush) begin
          stage_en_d = NSTAGE'(1);
        end else if (hit) begin
          if (last) begin
            commit_d  = 1'b1;
            instret_d = instret_q + CNT_W'(1);
            if (bus.halt_req) begin
              state_d    = HALT;
              stage_en_d = '0;
            end else begin
              stage_en_d = NSTAGE'(1);
            end
          end else begin
            stage_en_d = stage_en_q << 1;
          end
        end else if (wdog_fire) begin
          state_d    = HALT;
          stage_en_d = '0;
        end
      end
      HALT: begin
        stage_en_d = '0;
      end
      default: begin
        state_d    = IDLE;
        stage_en_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      stage_en_q <= '0;
      commit_q   <= 1'b0;
      instret_q  <= '0;
    end else begin
      state_q    <= state_d;
      stage_en_q <= stage_en_d;
      commit_q   <= commit_d;
      instret_q  <= instret_d;
    end
  end

  assign bus.stage_en = stage_en_q;
  assign bus.commit   = commit_q;
  assign bus.halted   = (state_q == HALT);
  assign bus.instret  = instret_q;

`ifdef YSYX_24110015_SEQ_WDOG_EN
  ysyx_24110015_seq_wdog #(
    .TMO_W(TMO_W)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .run      (state_q == RUN),
    .clear    (bus.flush | hit),
    .tmo_limit(bus.tmo_limit),
    .fire     (wdog_fire),
    .tmo_err  (bus.tmo_err)
  );
`else
  logic [TMO_W-1:0] unused_tmo_limit;
  assign unused_tmo_limit = bus.tmo_limit;
  assign wdog_fire        = 1'b0;
  assign bus.tmo_err      = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_24110015_stage_seq.sv
// Self-checking bench: vector table, directed corner sequences and randomized model compare.
module tb_ysyx_24110015_stage_seq;

  localparam int NST = 5;
`ifdef YSYX_24110015_SEQ_WDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] done_in, skip_in;
  logic       flush_in, halt_in;
  logic [7:0] lim_in;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ysyx_24110015_stage_seq_if #(.NSTAGE(NST), .CNT_W(32), .TMO_W(8)) bus_a ();
  ysyx_24110015_stage_seq_if #(.NSTAGE(NST), .CNT_W(4),  .TMO_W(8)) bus_b ();

  assign bus_a.stage_done = done_in;
  assign bus_a.stage_skip = skip_in;
  assign bus_a.flush      = flush_in;
  assign bus_a.halt_req   = halt_in;
  assign bus_a.tmo_limit  = lim_in;
  assign bus_b.stage_done = done_in;
  assign bus_b.stage_skip = skip_in;
  assign bus_b.flush      = flush_in;
  assign bus_b.halt_req   = halt_in;
  assign bus_b.tmo_limit  = lim_in;

  ysyx_24110015_stage_seq #(.NSTAGE(NST), .CNT_W(32), .TMO_W(8)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  ysyx_24110015_stage_seq #(.NSTAGE(NST), .CNT_W(4), .TMO_W(8)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  // Reference model: stage index, mode and retire count (0 idle, 1 run, 2 halt)
  int          m_mode = 0;
  int          m_k = 0;
  int          m_stall = 0;
  logic [31:0] m_ret = 0;
  bit          m_commit = 0;
  bit          m_tmo = 0;

  task automatic model_step();
    if (rst) begin
      m_mode = 0; m_k = 0; m_ret = 0; m_commit = 0; m_stall = 0; m_tmo = 0;
    end else begin
      m_commit = 0;
      if (m_mode == 0) begin
        m_mode = 1; m_k = 0;
      end else if (m_mode == 1) begin
        if (flush_in) begin
          m_k = 0; m_stall = 0;
        end else if (done_in[m_k] || skip_in[m_k]) begin
          m_stall = 0;
          if (m_k == NST - 1) begin
            m_commit = 1;
            m_ret    = m_ret + 1;
            if (halt_in) m_mode = 2;
            else m_k = 0;
          end else begin
            m_k = m_k + 1;
          end
        end else if (WDOG) begin
          m_stall = (m_stall + 1) % 256;
          if (lim_in != 0 && m_stall == int'(lim_in)) begin
            m_tmo = 1; m_mode = 2;
          end
        end
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [4:0] en, input logic c,
                         input logic h, input logic [31:0] ret, input logic tmo);
    chk({tag, ".stage_en"}, 32'(bus_a.stage_en), 32'(en));
    chk({tag, ".stage_en_b"}, 32'(bus_b.stage_en), 32'(en));
    chk({tag, ".commit"}, 32'(bus_a.commit), 32'(c));
    chk({tag, ".halted"}, 32'(bus_a.halted), 32'(h));
    chk({tag, ".instret"}, bus_a.instret, ret);
    chk({tag, ".instret_b"}, 32'(bus_b.instret), {28'd0, ret[3:0]});
    chk({tag, ".tmo_err"}, 32'(bus_a.tmo_err), 32'(tmo));
  endtask

  task automatic set_in(input logic [4:0] d, input logic [4:0] s, input logic f, input logic h);
    done_in = d; skip_in = s; flush_in = f; halt_in = h;
  endtask

  task automatic reset_and_start();
    set_in(5'd0, 5'd0, 1'b0, 1'b0);
    rst = 1'b1; step();
    rst = 1'b0; step();
  endtask

  task automatic go_stage2();
    set_in(5'b00001, 5'd0, 1'b0, 1'b0); step();
    set_in(5'b00010, 5'd0, 1'b0, 1'b0); step();
    set_in(5'b00000, 5'd0, 1'b0, 1'b0);
  endtask

  typedef struct packed {
    logic [4:0]  done;
    logic [4:0]  skip;
    logic        flush;
    logic        halt;
    logic [4:0]  en;
    logic        commit;
    logic        halted;
    logic [31:0] ret;
  } vec_t;

  vec_t vt [0:26];

  initial begin
    int ncommit;
    int stall_cnt;
    logic [7:0] lim_r;

    // done, skip, flush, halt | stage_en, commit, halted, instret
    vt[0]  = '{5'b00000, 5'b00000, 1'b0, 1'b0, 5'b00001, 1'b0, 1'b0, 32'd0};
    vt[1]  = '{5'b00001, 5'b00000, 1'b0, 1'b0, 5'b00010, 1'b0, 1'b0, 32'd0};
    vt[2]  = '{5'b00010, 5'b00000, 1'b0, 1'b0, 5'b00100, 1'b0, 1'b0, 32'd0};
    vt[3]  = '{5'b00100, 5'b00000, 1'b0, 1'b0, 5'b01000, 1'b0, 1'b0, 32'd0};
    vt[4]  = '{5'b01000, 5'b00000, 1'b0, 1'b0, 5'b10000, 1'b0, 1'b0, 32'd0};
    vt[5]  = '{5'b10000, 5'b00000, 1'b0, 1'b0, 5'b00001, 1'b1, 1'b0, 32'd1};
    vt[6]  = '{5'b00000, 5'b00000, 1'b0, 1'b0, 5'b00001, 1'b0, 1'b0, 32'd1};
    vt[7]  = '{5'b11110, 5'b11110, 1'b0, 1'b1, 5'b00001, 1'b0, 1'b0, 32'd1};
    vt[8]  = '{5'b00001, 5'b00000, 1'b0, 1'b1, 5'b00010, 1'b0, 1'b0, 32'd1};
    vt[9]  = '{5'b00010, 5'b01000, 1'b0, 1'b0, 5'b00100, 1'b0, 1'b0, 32'd1};
    vt[10] = '{5'b00100, 5'b01000, 1'b0, 1'b0, 5'b01000, 1'b0, 1'b0, 32'd1};
    vt[11] = '{5'b00000, 5'b01000, 1'b0, 1'b0, 5'b10000, 1'b0, 1'b0, 32'd1};
    vt[12] = '{5'b10000, 5'b01000, 1'b0, 1'b0, 5'b00001, 1'b1, 1'b0, 32'd2};
    vt[13] = '{5'b00001, 5'b00000, 1'b0, 1'b0, 5'b00010, 1'b0, 1'b0, 32'd2};
    vt[14] = '{5'b00010, 5'b00000, 1'b0, 1'b0, 5'b00100, 1'b0, 1'b0, 32'd2};
    vt[15] = '{5'b00100, 5'b00000, 1'b0, 1'b0, 5'b01000, 1'b0, 1'b0, 32'd2};
    vt[16] = '{5'b01000, 5'b00000, 1'b0, 1'b0, 5'b10000, 1'b0, 1'b0, 32'd2};
    vt[17] = '{5'b10000, 5'b00000, 1'b1, 1'b1, 5'b00001, 1'b0, 1'b0, 32'd2};
    vt[18] = '{5'b00001, 5'b00000, 1'b0, 1'b0, 5'b00010, 1'b0, 1'b0, 32'd2};
    vt[19] = '{5'b00000, 5'b00010, 1'b1, 1'b0, 5'b00001, 1'b0, 1'b0, 32'd2};
    vt[20] = '{5'b00001, 5'b00000, 1'b0, 1'b0, 5'b00010, 1'b0, 1'b0, 32'd2};
    vt[21] = '{5'b00010, 5'b00000, 1'b0, 1'b0, 5'b00100, 1'b0, 1'b0, 32'd2};
    vt[22] = '{5'b00100, 5'b00000, 1'b0, 1'b0, 5'b01000, 1'b0, 1'b0, 32'd2};
    vt[23] = '{5'b01000, 5'b00000, 1'b0, 1'b0, 5'b10000, 1'b0, 1'b0, 32'd2};
    vt[24] = '{5'b10000, 5'b00000, 1'b0, 1'b1, 5'b00000, 1'b1, 1'b1, 32'd3};
    vt[25] = '{5'b11111, 5'b00000, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b1, 32'd3};
    vt[26] = '{5'b00000, 5'b11111, 1'b1, 1'b1, 5'b00000, 1'b0, 1'b1, 32'd3};

    lim_in = 8'd0;
    set_in(5'd0, 5'd0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    chk_all("reset", 5'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 27; i++) begin
      set_in(vt[i].done, vt[i].skip, vt[i].flush, vt[i].halt);
      step();
      $display("row %0d: stage_en=%b commit=%b halted=%b instret=%0d",
               i, bus_a.stage_en, bus_a.commit, bus_a.halted, bus_a.instret);
      chk_all($sformatf("row%0d", i), vt[i].en, vt[i].commit, vt[i].halted, vt[i].ret, 1'b0);
    end

    // leave HALT only through reset
    set_in(5'b11111, 5'b11111, 1'b1, 1'b1);
    rst = 1'b1; step();
    chk_all("rst_halt", 5'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    rst = 1'b0;
    set_in(5'd0, 5'd0, 1'b0, 1'b0);
    step();
    chk_all("idle_to_run", 5'b00001, 1'b0, 1'b0, 32'd0, 1'b0);
    $display("seq halt_reset: halted=%b stage_en=%b", bus_a.halted, bus_a.stage_en);

    // 17 commits: the 4-bit counter wraps to 1
    ncommit = 0;
    for (int n = 0; n < 17; n++) begin
      for (int k = 0; k < NST; k++) begin
        set_in(5'(1 << k), 5'd0, 1'b0, 1'b0);
        step();
        if (bus_a.commit === 1'b1) ncommit++;
      end
      chk($sformatf("wrap_commit%0d", n), 32'(bus_a.commit), 32'd1);
    end
    chk("wrap_ncommit", ncommit, 32'd17);
    chk("wrap_instret_a", bus_a.instret, 32'd17);
    chk("wrap_instret_b", 32'(bus_b.instret), 32'd1);
    $display("seq wrap: commits=%0d instret_a=%0d instret_b=%0d", ncommit, bus_a.instret, bus_b.instret);

    // reset in the middle of stage 3 with every other input active
    for (int k = 0; k < 3; k++) begin
      set_in(5'(1 << k), 5'd0, 1'b0, 1'b0);
      step();
    end
    chk("mid_stage3_en", 32'(bus_a.stage_en), 32'b01000);
    lim_in = 8'd1;
    set_in(5'b01000, 5'b01000, 1'b1, 1'b1);
    rst = 1'b1; step();
    chk_all("rst_mid", 5'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    rst = 1'b0;
    set_in(5'd0, 5'd0, 1'b0, 1'b0);
    lim_in = 8'd0;
    step();
    chk_all("rst_mid_run", 5'b00001, 1'b0, 1'b0, 32'd0, 1'b0);
    $display("seq reset_mid: stage_en=%b instret=%0d", bus_a.stage_en, bus_a.instret);

    // watchdog stall on stage 2 with limit 10 (bounded wait)
    lim_in = 8'd10;
    reset_and_start();
    go_stage2();
    chk("wd_stage2", 32'(bus_a.stage_en), 32'b00100);
    stall_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (bus_a.halted === 1'b1) begin
        stall_cnt = c;
        break;
      end
    end
    chk("wd_fire_cycles", stall_cnt, WDOG ? 32'd10 : 32'd0);
    chk("wd_tmo_err", 32'(bus_a.tmo_err), 32'(WDOG));
    chk("wd_stage_en", 32'(bus_a.stage_en), WDOG ? 32'd0 : 32'b00100);
    $display("seq watchdog10: stall_cycles=%0d tmo_err=%b halted=%b", stall_cnt, bus_a.tmo_err, bus_a.halted);

    // flush clears the stall count
    reset_and_start();
    go_stage2();
    repeat (7) step();
    set_in(5'd0, 5'd0, 1'b1, 1'b0); step();
    go_stage2();
    repeat (9) step();
    chk("wd_flush_nofire", 32'(bus_a.halted), 32'd0);
    step();
    chk("wd_flush_fire", 32'(bus_a.halted), 32'(WDOG));
    $display("seq watchdog_flush: halted=%b tmo_err=%b", bus_a.halted, bus_a.tmo_err);

    // limit 0 never fires, even past counter wrap
    lim_in = 8'd0;
    reset_and_start();
    go_stage2();
    repeat (300) step();
    chk("wd0_halted", 32'(bus_a.halted), 32'd0);
    chk("wd0_tmo_err", 32'(bus_a.tmo_err), 32'd0);
    chk("wd0_stage_en", 32'(bus_a.stage_en), 32'b00100);
    $display("seq watchdog0: halted=%b tmo_err=%b", bus_a.halted, bus_a.tmo_err);

    // randomized traffic against the reference model
    for (int ep = 0; ep < 6; ep++) begin
      lim_r  = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(3, 20));
      lim_in = lim_r;
      reset_and_start();
      for (int c = 0; c < 350; c++) begin
        rst      = ($urandom_range(0, 99) == 0);
        done_in  = 5'($urandom) & 5'($urandom);
        skip_in  = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'd0;
        flush_in = ($urandom_range(0, 19) == 0);
        halt_in  = ($urandom_range(0, 29) == 0);
        if ($urandom_range(0, 3) == 0) done_in = 5'd0;
        step();
        chk_all($sformatf("rand%0d_%0d", ep, c),
                (m_mode == 1) ? 5'(5'b00001 << m_k) : 5'b0,
                m_commit, (m_mode == 2), m_ret, m_tmo);
        if (bus_a.commit === 1'b1)
          $display("rand ep=%0d cyc=%0d commit instret=%0d", ep, c, bus_a.instret);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
